// File: rtl/bus_cycle_pkg.sv
// Shared types and widths for the bus-cycle terminator.
// The state encoding is fixed here so that checkers and debug tools see the same values.
package bus_cycle_pkg;

    localparam int WAIT_WIDTH = 4;
    localparam int TO_WIDTH   = 8;
    localparam int IDX_WIDTH  = 3;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        COUNT     = 3'd1,
        ACK       = 3'd2,
        UNCLAIMED = 3'd3,
        BERR      = 3'd4
    } bus_state_e;

endpackage

// File: rtl/bus_cycle_controller_if.sv
// CPU-side bus handshake and wait-count config port of the bus-cycle terminator.
// The master modport is the CPU/decoder side; the slave modport is the controller.
interface bus_cycle_controller_if
    import bus_cycle_pkg::*;
#(
    parameter int NUM_REGIONS = 4
);

    logic                   cycle_active;
    logic [NUM_REGIONS-1:0] cs;
    logic                   cfg_write;
    logic [IDX_WIDTH-1:0]   cfg_region;
    logic [WAIT_WIDTH-1:0]  cfg_wait;
    logic                   waitstate;
    logic                   bus_error;
    logic                   cycle_done;
    logic                   multi_cs_error;

    modport master (
        output cycle_active, cs, cfg_write, cfg_region, cfg_wait,
        input  waitstate, bus_error, cycle_done, multi_cs_error
    );

    modport slave (
        input  cycle_active, cs, cfg_write, cfg_region, cfg_wait,
        output waitstate, bus_error, cycle_done, multi_cs_error
    );

endinterface

// File: rtl/region_select_encoder.sv
// Combinational chip-select priority encoder: lowest set cs bit wins.
// Also flags whether any or more than one region is selected.
module region_select_encoder
    import bus_cycle_pkg::*;
#(
    parameter int NUM_REGIONS = 4
) (
    input  logic [NUM_REGIONS-1:0] cs,
    output logic [IDX_WIDTH-1:0]   region,
    output logic                   any_hit,
    output logic                   multi_hit
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        region = {IDX_WIDTH{1'b0}};
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            region = cs[i] ? IDX_WIDTH'(i) : region;
        end
    end

    // Clearing the lowest set bit leaves something only when two or more were set.
    always_comb begin
        any_hit   = |cs;
        multi_hit = (cs & (cs - {{(NUM_REGIONS-1){1'b0}}, 1'b1})) != {NUM_REGIONS{1'b0}};
    end

endmodule

// File: rtl/bus_cycle_controller.sv
// Shared bus-cycle sequencer: applies a programmable per-region wait count to each
// claimed cycle and ends unclaimed cycles with a bus error after a timeout.
module bus_cycle_controller
    import bus_cycle_pkg::*;
#(
    parameter int                    NUM_REGIONS  = 4,
    parameter logic [WAIT_WIDTH-1:0] DEFAULT_WAIT = 4'h1,
    parameter logic [TO_WIDTH-1:0]   TIMEOUT      = 8'd255
) (
    input  logic                 clock,
    input  logic                 reset,
    bus_cycle_controller_if.slave bus
);

    bus_state_e            state_r;
    bus_state_e            state_s;
    logic [IDX_WIDTH-1:0]  region_r;
    logic [WAIT_WIDTH-1:0] target_r;
    logic [WAIT_WIDTH-1:0] wait_cnt_r;
    logic [TO_WIDTH-1:0]   to_cnt_r;
    logic [WAIT_WIDTH-1:0] wait_r [NUM_REGIONS];
    logic                  waitstate_r;
    logic                  bus_error_r;
    logic                  cycle_done_r;
    logic                  multi_cs_error_r;

    logic [IDX_WIDTH-1:0]  region_s;
    logic                  any_hit_s;
    logic                  multi_hit_s;
    logic [WAIT_WIDTH-1:0] sel_wait_s;
    logic                  cs_region_s;
    logic                  start_s;
    logic                  to_clr_s;
    logic                  cnt_inc_s;
    logic                  to_inc_s;
    logic                  done_s;

    region_select_encoder #(
        .NUM_REGIONS (NUM_REGIONS)
    ) u_encoder (
        .cs        (bus.cs),
        .region    (region_s),
        .any_hit   (any_hit_s),
        .multi_hit (multi_hit_s)
    );

    // Wait count of the newly decoded region and live cs bit of the latched region.
    always_comb begin
        sel_wait_s  = {WAIT_WIDTH{1'b0}};
        cs_region_s = 1'b0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            sel_wait_s  = (region_s == IDX_WIDTH'(i)) ? wait_r[i] : sel_wait_s;
            cs_region_s = (region_r == IDX_WIDTH'(i)) ? bus.cs[i] : cs_region_s;
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_s   = state_r;
        start_s   = 1'b0;
        to_clr_s  = 1'b0;
        cnt_inc_s = 1'b0;
        to_inc_s  = 1'b0;
        done_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.cycle_active && any_hit_s) begin
                    start_s = 1'b1;
                    state_s = COUNT;
                end else if (bus.cycle_active) begin
                    to_clr_s = 1'b1;
                    state_s  = UNCLAIMED;
                end else begin
                    state_s = IDLE;
                end
            end
            COUNT: begin
                if (!bus.cycle_active || !cs_region_s) begin
                    state_s = IDLE;
                end else if (wait_cnt_r == target_r) begin
                    state_s = ACK;
                end else begin
                    cnt_inc_s = 1'b1;
                end
            end
            ACK, BERR: begin
                if (!bus.cycle_active) begin
                    state_s = IDLE;
                    done_s  = 1'b1;
                end else begin
                    state_s = state_r;
                end
            end
            UNCLAIMED: begin
                // Late decode takes priority over the timeout on the same edge.
                if (!bus.cycle_active) begin
                    state_s = IDLE;
                end else if (any_hit_s) begin
                    start_s = 1'b1;
                    state_s = COUNT;
                end else if (to_cnt_r == (TIMEOUT - 8'd1)) begin
                    state_s = BERR;
                end else begin
                    to_inc_s = 1'b1;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, counters and registered outputs; outputs follow the state being entered.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r          <= IDLE;
            region_r         <= {IDX_WIDTH{1'b0}};
            target_r         <= {WAIT_WIDTH{1'b0}};
            wait_cnt_r       <= {WAIT_WIDTH{1'b0}};
            to_cnt_r         <= {TO_WIDTH{1'b0}};
            waitstate_r      <= 1'b1;
            bus_error_r      <= 1'b0;
            cycle_done_r     <= 1'b0;
            multi_cs_error_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            waitstate_r  <= (state_s != ACK);
            bus_error_r  <= (state_s == BERR);
            cycle_done_r <= done_s;
            if (start_s) begin
                region_r   <= region_s;
                target_r   <= sel_wait_s;
                wait_cnt_r <= {WAIT_WIDTH{1'b0}};
                if (multi_hit_s) begin
                    multi_cs_error_r <= 1'b1;
                end
            end else if (cnt_inc_s) begin
                wait_cnt_r <= wait_cnt_r + 4'd1;
            end
            if (to_clr_s) begin
                to_cnt_r <= {TO_WIDTH{1'b0}};
            end else if (to_inc_s) begin
                to_cnt_r <= to_cnt_r + 8'd1;
            end
        end
    end

    // Per-region wait registers; an out-of-range index matches no entry.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGIONS; i++) begin
                wait_r[i] <= DEFAULT_WAIT;
            end
        end else if (bus.cfg_write) begin
            for (int i = 0; i < NUM_REGIONS; i++) begin
                if (bus.cfg_region == IDX_WIDTH'(i)) begin
                    wait_r[i] <= bus.cfg_wait;
                end
            end
        end
    end

    assign bus.waitstate      = waitstate_r;
    assign bus.bus_error      = bus_error_r;
    assign bus.cycle_done     = cycle_done_r;
    assign bus.multi_cs_error = multi_cs_error_r;

endmodule

// File: doc/bus_cycle_controller.md
Name: bus_cycle_controller

Overview:
- Central bus-cycle terminator for the CPU bus. Watches the decoded chip selects and the qualified address strobe.
- For each cycle it picks the active region and applies that region's programmable wait count, then releases the wait state.
- Cycles that select no region are ended with a bus error after a timeout.
- Per-region wait counts are written through a small config port. This replaces fixed per-device wait logic with one shared, configurable sequencer.

Parameters:
- NUM_REGIONS, 4, number of chip-select regions (2..8).
- DEFAULT_WAIT, 4'h1, wait count loaded into every region register at reset.
- TIMEOUT, 8'd255, cycles of unclaimed strobe before bus_error (1..255).

Ports:
- clock  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- cycle_active  input  1  high while the CPU bus cycle is in progress (qualified address strobe).
- cs  input  NUM_REGIONS  active-high chip selects, one per region.
- cfg_write  input  1  one-cycle strobe; writes cfg_wait into region cfg_region.
- cfg_region  input  3  target region index; writes with index >= NUM_REGIONS are ignored.
- cfg_wait  input  4  new wait count (0..15).
- waitstate  output  1  high = hold the CPU; low = terminate the cycle.
- bus_error  output  1  high = terminate the cycle with a bus error.
- cycle_done  output  1  one-cycle pulse when a cycle leaves ACK or BERR.
- multi_cs_error  output  1  sticky flag; set when more than one cs bit is high at cycle start.

Behaviour:
- Reset values:
  - state IDLE, waitstate=1, bus_error=0, cycle_done=0, multi_cs_error=0.
  - All wait registers = DEFAULT_WAIT; counters = 0.
  - Reset asserted mid-cycle abandons the cycle immediately, with the same values.
- States: IDLE, COUNT, ACK, UNCLAIMED, BERR.
- IDLE:
  - If cycle_active && |cs: latch the lowest-index set cs bit as the region, latch wait[region] into target, clear wait_cnt, go to COUNT.
  - If cycle_active && !|cs: clear to_cnt, go to UNCLAIMED.
  - If more than one cs bit is high at the start edge, set multi_cs_error; it stays set until reset.
- COUNT:
  - When wait_cnt == target, go to ACK; otherwise wait_cnt += 1.
  - If cycle_active or cs[region] drops, return to IDLE with no cycle_done.
  - Latency: with target N, waitstate falls after edge S+N+1, where S is the start edge.
  - target 0 gives one-clock latency; target 1 gives two clocks.
- ACK:
  - waitstate=0, held until cycle_active falls.
  - On that edge: go to IDLE, pulse cycle_done for one cycle, and waitstate returns to 1.
- UNCLAIMED:
  - to_cnt increments each clock.
  - If a cs rises while cycle_active is still high, behave as the IDLE start (late decode), with to_cnt discarded.
  - When to_cnt == TIMEOUT-1, go to BERR.
  - If cycle_active drops, go to IDLE silently.
- BERR:
  - bus_error=1 and waitstate=1, held until cycle_active falls.
  - Then go to IDLE, pulse cycle_done, and clear bus_error.
- Config writes:
  - Accepted in every state.
  - A write takes effect for cycles that start after the write edge.
  - A write on the same edge as a start of the same region: the start uses the old value, the new value is used from the next cycle.
  - An in-flight target is never altered.
- Width rules:
  - wait_cnt is 4 bits and never wraps, because it stops at target (<= 15).
  - to_cnt is 8 bits and saturates at TIMEOUT-1.
- waitstate and bus_error are never both low-terminating; bus_error=1 always implies waitstate=1.

Decomposition:
- Shared package bus_cycle_pkg holds:
  - State encoding constants (IDLE, COUNT, ACK, UNCLAIMED, BERR; 3-bit).
  - WAIT_WIDTH=4 and TO_WIDTH=8.
- One natural sub-module, region_select_encoder. It is combinational and maps cs to:
  - region index (lowest set bit),
  - any-hit,
  - multi-hit.
- Everything else stays in bus_cycle_controller.

Test Plan:
- Reset defaults, region 0 selected with wait 1: cycle_active and cs=4'b0001 at edge S -> waitstate falls after edge S+2 and stays 0 until cycle_active falls; cycle_done pulses once; waitstate is 1 the next cycle.
- Configure then run: write region 2 wait=0, then region 3 wait=15; cycles on cs=4'b0100 and cs=4'b1000 -> waitstate falls after S+1 and S+16 respectively.
- Unclaimed cycle with TIMEOUT=8: cycle_active high and cs=0 -> bus_error rises after edge S+8 with waitstate=1; bus_error clears and cycle_done pulses when cycle_active falls. A separate run with cs asserted at S+3 -> normal termination with no bus_error.
- Multi-select and abort:
  - cs=4'b0110 at start -> region 1 timing used and multi_cs_error set until reset.
  - cs[1] dropped during COUNT -> state returns to IDLE, no cycle_done, waitstate=1.
- Write/start collision and mid-cycle reset:
  - Write region 0 wait=5 on the start edge of a region 0 cycle with old wait 1 -> this cycle terminates at S+2, the next at S+6.
  - reset asserted in ACK -> waitstate=1, bus_error=0, and all wait registers back to DEFAULT_WAIT.
